// File: rtl/a_serializer.sv
// Parallel-to-serial stage: one-word holding register in front of a shifter,
// streaming DW-bit words onto a single-bit lane with first/last framing strobes.
module a_serializer #(
   parameter int DW        = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] a,
   input  logic          a_valid,
   output logic          a_ready,
   input  logic          b_stall,
   output logic          b,
   output logic          b_valid,
   output logic          b_first,
   output logic          b_last
);

   // state | meaning
   // IDLE  | shifter empty, waiting for the hold register to fill
   // SHIFT | shifter driving a live bit onto b every unstalled cycle
   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   localparam int             CW       = (DW > 1) ? $clog2(DW) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(DW - 1);

   state_t          state_q;
   logic [DW-1:0]   hold_q, hold_d;
   logic            hold_full_q, hold_full_d;
   logic [DW-1:0]   sh_q, sh_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic            busy;
   logic            accept;
   logic            adv;
   logic            at_last;
   logic            load;

   assign busy    = (state_q == SHIFT);
   assign a_ready = ~hold_full_q;
   assign accept  = a_valid & ~hold_full_q;
   assign adv     = busy & ~b_stall;
   assign at_last = (cnt_q == CNT_LAST);
   assign load    = hold_full_q & (~busy | (adv & at_last));

   always_comb begin
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      sh_d        = sh_q;
      cnt_d       = cnt_q;

      if (accept) begin
         hold_d = a;
      end
      // an accept on the same edge as a load must leave the holding register full
      if (accept) begin
         hold_full_d = 1'b1;
      end else if (load) begin
         hold_full_d = 1'b0;
      end

      if (load) begin
         sh_d  = hold_q;
         cnt_d = '0;
      end else if (adv && !at_last) begin
         sh_d  = LSB_FIRST ? (sh_q >> 1) : (sh_q << 1);
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         sh_q        <= '0;
         cnt_q       <= '0;
      end else begin
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         sh_q        <= sh_d;
         cnt_q       <= cnt_d;
         case (state_q)
            IDLE:    if (load) state_q <= SHIFT;
            SHIFT:   if (adv && at_last && !load) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign b       = LSB_FIRST ? sh_q[0] : sh_q[DW-1];
   assign b_valid = busy;
   assign b_first = busy & (cnt_q == '0);
   assign b_last  = busy & at_last;

endmodule

// File: tb/tb_a_serializer.sv
// Directed bench for a_serializer: DW=8 LSB-first, DW=8 MSB-first and DW=1
// instances checked against hand-computed bit sequences.
module tb_a_serializer;

   logic       clk;
   logic       rst_n;
   logic [7:0] a;
   logic       a_valid;
   logic       b_stall;

   logic       a_ready0, b0, b_valid0, b_first0, b_last0;
   logic       a_ready1, b1, b_valid1, b_first1, b_last1;

   logic [0:0] a2;
   logic       a_valid2;
   logic       a_ready2, b2, b_valid2, b_first2, b_last2;

   int n_chk;
   int n_fail;

   a_serializer #(.DW(8), .LSB_FIRST(1'b1)) u_lsb (
      .clk(clk), .rst_n(rst_n), .a(a), .a_valid(a_valid), .a_ready(a_ready0),
      .b_stall(b_stall), .b(b0), .b_valid(b_valid0), .b_first(b_first0), .b_last(b_last0)
   );

   a_serializer #(.DW(8), .LSB_FIRST(1'b0)) u_msb (
      .clk(clk), .rst_n(rst_n), .a(a), .a_valid(a_valid), .a_ready(a_ready1),
      .b_stall(b_stall), .b(b1), .b_valid(b_valid1), .b_first(b_first1), .b_last(b_last1)
   );

   a_serializer #(.DW(1), .LSB_FIRST(1'b1)) u_dw1 (
      .clk(clk), .rst_n(rst_n), .a(a2), .a_valid(a_valid2), .a_ready(a_ready2),
      .b_stall(b_stall), .b(b2), .b_valid(b_valid2), .b_first(b_first2), .b_last(b_last2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // exp_* bit i is the i-th bit emitted on b
   typedef struct {
      logic [7:0] word;
      logic [7:0] exp_lsb;
      logic [7:0] exp_msb;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic send_one(input vec_t v);
      @(negedge clk);
      a       = v.word;
      a_valid = 1'b1;
      @(negedge clk);
      a_valid = 1'b0;
      chk("ready_after_accept", a_ready0, 0);
      chk("valid_before_load", b_valid0, 0);
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         chk("lsb_b", b0, v.exp_lsb[i]);
         chk("lsb_valid", b_valid0, 1);
         chk("lsb_first", b_first0, (i == 0));
         chk("lsb_last", b_last0, (i == 7));
         chk("msb_b", b1, v.exp_msb[i]);
         chk("msb_valid", b_valid1, 1);
         @(negedge clk);
      end
      chk("lsb_valid_after", b_valid0, 0);
      chk("msb_valid_after", b_valid1, 0);
      chk("ready_after_word", a_ready0, 1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready0"}, a_ready0, 1);
      chk({tag, "_b0"}, b0, 0);
      chk({tag, "_valid0"}, b_valid0, 0);
      chk({tag, "_first0"}, b_first0, 0);
      chk({tag, "_last0"}, b_last0, 0);
      chk({tag, "_valid1"}, b_valid1, 0);
      chk({tag, "_ready2"}, a_ready2, 1);
      chk({tag, "_valid2"}, b_valid2, 0);
   endtask

   initial begin
      logic [15:0] b2b_exp;
      logic [7:0]  f0_exp;
      int          idx;

      vecs[0] = '{word: 8'hA5, exp_lsb: 8'hA5, exp_msb: 8'hA5};
      vecs[1] = '{word: 8'h80, exp_lsb: 8'h80, exp_msb: 8'h01};
      vecs[2] = '{word: 8'h12, exp_lsb: 8'h12, exp_msb: 8'h48};
      vecs[3] = '{word: 8'hF0, exp_lsb: 8'hF0, exp_msb: 8'h0F};
      vecs[4] = '{word: 8'h01, exp_lsb: 8'h01, exp_msb: 8'h80};

      n_chk    = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      a        = '0;
      a_valid  = 1'b0;
      b_stall  = 1'b0;
      a2       = '0;
      a_valid2 = 1'b0;

      #2;
      chk_reset_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk_reset_outputs("post_release");

      for (int k = 0; k < 5; k++) begin
         send_one(vecs[k]);
      end

      // back-to-back A5 then 3C with a_valid held high
      b2b_exp = 16'h3CA5;
      @(negedge clk);
      a       = 8'hA5;
      a_valid = 1'b1;
      @(negedge clk);
      chk("b2b_ready_low", a_ready0, 0);
      a = 8'h3C;
      @(negedge clk);
      for (int j = 0; j < 16; j++) begin
         chk("b2b_b", b0, b2b_exp[j]);
         chk("b2b_valid", b_valid0, 1);
         chk("b2b_first", b_first0, (j == 0 || j == 8));
         chk("b2b_last", b_last0, (j == 7 || j == 15));
         chk("b2b_ready", a_ready0, (j == 0 || j >= 8));
         if (j == 1) a_valid = 1'b0;
         @(negedge clk);
      end
      chk("b2b_idle", b_valid0, 0);

      // stall for 3 edges while bit 3 of F0 is on b; accept 12 during the stall
      f0_exp = 8'hF0;
      @(negedge clk);
      a       = 8'hF0;
      a_valid = 1'b1;
      @(negedge clk);
      a_valid = 1'b0;
      @(negedge clk);
      for (int j = 0; j < 11; j++) begin
         idx = (j <= 3) ? j : ((j <= 6) ? 3 : j - 3);
         chk("stall_b", b0, f0_exp[idx]);
         chk("stall_valid", b_valid0, 1);
         chk("stall_first", b_first0, (j == 0));
         chk("stall_last", b_last0, (j == 10));
         if (j == 3) b_stall = 1'b1;
         if (j == 6) b_stall = 1'b0;
         if (j == 4) begin
            chk("stall_ready_free", a_ready0, 1);
            a       = 8'h12;
            a_valid = 1'b1;
         end
         if (j == 5) begin
            chk("stall_accept", a_ready0, 0);
            a_valid = 1'b0;
         end
         @(negedge clk);
      end
      chk("stall_reload_valid", b_valid0, 1);
      chk("stall_reload_first", b_first0, 1);
      chk("stall_reload_b", b0, 0);
      chk("stall_reload_ready", a_ready0, 1);
      repeat (10) @(negedge clk);
      chk("stall_drained", b_valid0, 0);

      // asynchronous reset in the middle of FF
      @(negedge clk);
      a       = 8'hFF;
      a_valid = 1'b1;
      @(negedge clk);
      a_valid = 1'b0;
      @(negedge clk);
      repeat (4) @(negedge clk);
      chk("midword_b_before", b0, 1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midword_reset");
      @(negedge clk);
      rst_n = 1'b1;
      chk("midword_release_ready", a_ready0, 1);
      chk("midword_release_valid", b_valid0, 0);
      send_one(vecs[4]);

      // DW=1: each word is a single first-and-last bit
      @(negedge clk);
      a2       = 1'b1;
      a_valid2 = 1'b1;
      @(negedge clk);
      a_valid2 = 1'b0;
      chk("dw1_ready_low", a_ready2, 0);
      chk("dw1_pre_valid", b_valid2, 0);
      @(negedge clk);
      chk("dw1_b", b2, 1);
      chk("dw1_valid", b_valid2, 1);
      chk("dw1_first", b_first2, 1);
      chk("dw1_last", b_last2, 1);
      chk("dw1_ready_back", a_ready2, 1);
      a2       = 1'b0;
      a_valid2 = 1'b1;
      @(negedge clk);
      a_valid2 = 1'b0;
      chk("dw1_gap_valid", b_valid2, 0);
      @(negedge clk);
      chk("dw1_b0", b2, 0);
      chk("dw1_valid0", b_valid2, 1);
      chk("dw1_first0", b_first2, 1);
      chk("dw1_last0", b_last2, 1);
      @(negedge clk);
      chk("dw1_idle", b_valid2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/a_serializer.md
# a_serializer

Parallel-to-serial stage that sits directly upstream of `child`. It accepts DW-bit words on a valid/ready handshake and drives them one bit per cycle onto the single-bit `b` lane that `child` consumes. A one-word holding register lets the next word be accepted while the current one shifts out, so back-to-back words stream with no idle cycles. Framing strobes mark the first and last bit of each word.

## Interface
- DW, default 8: word width in bits; legal range 1..64.
- LSB_FIRST, default 1: 1 shifts bit 0 out first; 0 shifts bit DW-1 out first.

- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  DW  parallel word.
- a_valid  input  1  `a` is valid this cycle.
- a_ready  output  1  holding register is empty; a word is accepted on any edge where `a_valid && a_ready`.
- b_stall  input  1  downstream hold request; freezes the shifter.
- b  output  1  serial data bit (registered).
- b_valid  output  1  `b` carries a live bit.
- b_first  output  1  `b` is the first bit of a word.
- b_last  output  1  `b` is the last bit of a word.

## Operation
- Storage:
  - hold register `hold[DW-1:0]` plus `hold_full` flag.
  - shift register `sh[DW-1:0]`.
  - bit counter `cnt`, width max(1, clog2(DW)).
  - state flag `busy`.
- `a_ready = !hold_full`, combinational from the flop only. It does not depend on `a_valid` or `b_stall`.
- Accept: on an edge with `a_valid && a_ready`, set `hold <= a` and `hold_full <= 1`.
- Advance: `adv = busy && !b_stall`.
- Load condition: `hold_full && (!busy || (adv && cnt == DW-1))`. On a load edge:
  - set `sh <= hold`, `cnt <= 0`, `busy <= 1`;
  - clear `hold_full` unless an accept occurs on the same edge. An accept can only coincide with a load when the hold register was already empty, so this case never arises; the pointer logic must still be written so the accept has priority.
- On an edge with `adv` and no load:
  - if `cnt == DW-1`, clear `busy` (word done, hold empty);
  - otherwise set `cnt <= cnt+1` and shift `sh` by one position toward the output end.
- States:
  - IDLE (`busy=0`) → SHIFT on load.
  - SHIFT → SHIFT while bits remain, or on a last bit with `hold_full` (seamless reload).
  - SHIFT → IDLE on a last bit with `hold_full=0`.
- Outputs:
  - `b` is the output-end bit of `sh`: bit 0 if LSB_FIRST, bit DW-1 otherwise.
  - `b_valid = busy`, `b_first = busy && cnt==0`, `b_last = busy && cnt==DW-1`.
  - All outputs are derived from flops only.
- `b_stall` freezes `sh`, `cnt`, `busy` and all b-side outputs. The accept path keeps operating.
- DW=1: `b_first` and `b_last` are both high on every valid bit, and every word is a last bit.
- Reset (asynchronous, mid-word or idle): clears `busy`, `hold_full`, `cnt` and `sh`. Any partial word is discarded with no flush.

## Timing
- Reset values: `a_ready=1`, `b=0`, `b_valid=0`, `b_first=0`, `b_last=0`.
- Latency, accept to first bit:
  - a word accepted at edge k is loaded at edge k+1;
  - `b_valid`/`b_first` are high in the cycle after edge k+1.
- Throughput: one word per DW cycles with zero bubbles while `a_valid` stays high and `b_stall` stays low.
- `a_ready` behaviour in steady streaming:
  - goes low the cycle after an accept;
  - returns high the cycle after the load that empties the hold register.
- `b_stall` takes effect at the very next edge, with no skid on the b side.
- Release of `rst_n` is synchronised externally; the first accept is legal on the first edge after deassertion.

## Test plan
- Reset: assert `rst_n=0` mid-stream → all outputs reach their reset values immediately, without waiting for a clock edge. After release, `a_ready=1` and `b_valid=0`.
- Single word, DW=8, LSB_FIRST=1, `a=8'hA5` accepted at edge 0 → from cycle 2, `b` = 1,0,1,0,0,1,0,1. `b_first` is high on the first bit, `b_last` on the eighth, then `b_valid=0`.
- Back-to-back `8'hA5` then `8'h3C`, `a_valid` held high → 16 consecutive valid bits with no gap. `b_last` is followed directly by `b_first`, and `a_ready` toggles as specified.
- Stall: `8'hF0`, with `b_stall=1` for 3 cycles while `cnt==3` → `b`, `b_valid` and `cnt` are frozen for 3 cycles. The remaining bits follow unchanged, and the total word duration is 11 cycles.
- Reset mid-word: `rst_n` pulsed low at bit 4 of `8'hFF`, then `8'h01` sent → no residual bits. The new word emits 1,0,0,0,0,0,0,0.
- LSB_FIRST=0, `a=8'h80` → first bit 1, then seven 0s. DW=1: word 1'b1 → single bit with `b_first=b_last=1`.
